// File: rtl/vga_timing_pkg.sv
// 640x480 @ 60 Hz VGA timing constants and the coordinate type shared with
// the pixel generator.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC - 1;
  localparam int VS_START = V_DISPLAY + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC - 1;

  // Inclusive window test on a coordinate.
  function automatic logic in_range(coord_t val, int lo, int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_if.sv
// VGA timing bundle from vga_sync to the pixel generator and connector.
// frame_start exists only when VGA_FRAME_START_EN is defined.
interface vga_sync_if;
  import vga_timing_pkg::*;

  // Free-running stream: no valid/ready, every signal is meaningful on every
  // clock and p_tick marks the clocks on which the position advances.
  logic   p_tick;
  coord_t x;
  coord_t y;
  logic   video_on;
  logic   hsync;
  logic   vsync;
`ifdef VGA_FRAME_START_EN
  logic   frame_start;
`endif

  modport master (
    output p_tick, x, y, video_on, hsync, vsync
`ifdef VGA_FRAME_START_EN
    , output frame_start
`endif
  );

  modport slave (
    input p_tick, x, y, video_on, hsync, vsync
`ifdef VGA_FRAME_START_EN
    , input frame_start
`endif
  );

endinterface

// File: rtl/vga_tick_gen.sv
// Clock divider: tick is high for one clock out of every DIV clocks.
// Also used for game-timer ticks.
module vga_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (div_q == W'(DIV - 1)) div_d = '0;
    else                      div_d = div_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  // Decoded from the register, so with DIV=1 the tick is constantly high.
  assign tick = (div_q == W'(DIV - 1));

endmodule

// File: rtl/vga_sync.sv
// VGA horizontal/vertical counters and sync decode.
// Define VGA_FRAME_START_EN to add the frame_start pulse output.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BACK    = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);
  import vga_timing_pkg::*;

  localparam int H_LAST      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_LAST      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;
  localparam int HSYNC_FIRST = H_DISPLAY + H_FRONT;
  localparam int HSYNC_LAST  = HSYNC_FIRST + H_SYNC - 1;
  localparam int VSYNC_FIRST = V_DISPLAY + V_FRONT;
  localparam int VSYNC_LAST  = VSYNC_FIRST + V_SYNC - 1;

  logic   p_tick;
  logic   h_wrap;
  logic   v_wrap;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;
  logic   video_on_q, video_on_d;

  vga_tick_gen #(
    .DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (p_tick)
  );

  // Sync and blanking are decoded from the next-state counters so that the
  // registered versions line up with x/y in the same clock.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    h_wrap = p_tick && (h_q == coord_t'(H_LAST));
    v_wrap = h_wrap && (v_q == coord_t'(V_LAST));
    if (p_tick) h_d = h_wrap ? '0 : h_q + coord_t'(1);
    if (h_wrap) v_d = v_wrap ? '0 : v_q + coord_t'(1);
    hsync_d    = !in_range(h_d, HSYNC_FIRST, HSYNC_LAST);
    vsync_d    = !in_range(v_d, VSYNC_FIRST, VSYNC_LAST);
    video_on_d = (h_d < coord_t'(H_DISPLAY)) && (v_d < coord_t'(V_DISPLAY));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
    end else begin
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
    end
  end

  assign vga.p_tick   = p_tick;
  assign vga.x        = h_q;
  assign vga.y        = v_q;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_on_q;

`ifdef VGA_FRAME_START_EN
  logic frame_start_q;
  logic frame_start_d;

  // High for the first clock of (0,0) after a frame wrap, never out of reset.
  always_comb frame_start_d = v_wrap;

  always_ff @(posedge clk) begin
    if (reset) frame_start_q <= 1'b0;
    else       frame_start_q <= frame_start_d;
  end

  assign vga.frame_start = frame_start_q;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: one instance at full 640x480 timing, one at a tiny
// timing with CLK_DIV=1 so whole frames fit in a short run.
module tb_vga_sync;

  logic clk;
  logic rst_a;
  logic rst_b;

  int n_cmp = 0;
  int n_err = 0;

  // Clocks since reset was last sampled high; -1 before the first reset.
  longint k_a = -1;
  longint k_b = -1;

  logic [24:0] exp_q[$];

  int hs_low_a  = 0;
  int vid_off_a = 0;
  int vs_low_b  = 0;
  int tgt_b     = 0;
  int fs_cnt_b  = 0;

  vga_sync_if if_a ();
  vga_sync_if if_b ();

  vga_sync u_dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (if_a)
  );

  vga_sync #(
    .CLK_DIV   (1),
    .H_DISPLAY (8),
    .H_FRONT   (2),
    .H_SYNC    (3),
    .H_BACK    (3),
    .V_DISPLAY (5),
    .V_FRONT   (2),
    .V_SYNC    (2),
    .V_BACK    (2)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (if_b)
  );

  logic fs_a, fs_b;
`ifdef VGA_FRAME_START_EN
  assign fs_a = if_a.frame_start;
  assign fs_b = if_b.frame_start;
`else
  assign fs_a = 1'b0;
  assign fs_b = 1'b0;
`endif

  logic [24:0] obs_a, obs_b;
  assign obs_a = {fs_a, if_a.p_tick, if_a.x, if_a.y, if_a.video_on, if_a.hsync, if_a.vsync};
  assign obs_b = {fs_b, if_b.p_tick, if_b.x, if_b.y, if_b.video_on, if_b.hsync, if_b.vsync};

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    k_a <= rst_a ? 64'sd0 : ((k_a < 0) ? -64'sd1 : k_a + 1);
    k_b <= rst_b ? 64'sd0 : ((k_b < 0) ? -64'sd1 : k_b + 1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the output is a pure function of clocks elapsed since reset.
  // Pixel index = k / d, position = pixel index modulo frame size.
  function automatic logic [24:0] model(longint k, int d, int hd, int hf, int hs, int hb,
                                        int vd, int vf, int vs, int vb);
    longint ht, vt, t, pos, xm, ym;
    logic pt, vid, hsn, vsn, fs;
    ht  = hd + hf + hs + hb;
    vt  = vd + vf + vs + vb;
    t   = k / d;
    pos = t % (ht * vt);
    xm  = pos % ht;
    ym  = pos / ht;
    pt  = ((k % d) == (d - 1));
    if (k == 0) begin
      vid = 1'b0; hsn = 1'b1; vsn = 1'b1; fs = 1'b0;
    end else begin
      vid = (xm < hd) && (ym < vd);
      hsn = !((xm >= hd + hf) && (xm < hd + hf + hs));
      vsn = !((ym >= vd + vf) && (ym < vd + vf + vs));
`ifdef VGA_FRAME_START_EN
      fs  = (pos == 0) && ((k % d) == 0) && (t > 0);
`else
      fs  = 1'b0;
`endif
    end
    return {fs, pt, xm[9:0], ym[9:0], vid, hsn, vsn};
  endfunction

  // scoreboard: every clock, both instances against the model
  always @(negedge clk) begin
    if (k_a >= 0) exp_q.push_back(model(k_a, 4, 640, 16, 96, 48, 480, 10, 2, 33));
    if (k_b >= 0) exp_q.push_back(model(k_b, 1, 8, 2, 3, 3, 5, 2, 2, 2));
    if (k_a >= 0) check("out_a", obs_a, exp_q.pop_front());
    if (k_b >= 0) check("out_b", obs_b, exp_q.pop_front());

    if (k_a == 0) begin
      hs_low_a  = 0;
      vid_off_a = 0;
    end else if (k_a > 0) begin
      if (!if_a.hsync)    hs_low_a++;
      if (!if_a.video_on) vid_off_a++;
    end
    if (k_b == 0) begin
      vs_low_b = 0;
      tgt_b    = 0;
      fs_cnt_b = 0;
    end else if (k_b > 0) begin
      if (!if_b.vsync) vs_low_b++;
      if (if_b.p_tick && if_b.x == 10'd0 && if_b.y == 10'd6) tgt_b++;
      if (fs_b) fs_cnt_b++;
    end
  end

  // driver tasks
  task automatic drive_reset(input bit sel_b, input int len);
    @(negedge clk);
    #1;
    if (sel_b) rst_b = 1'b1;
    else       rst_a = 1'b1;
    repeat (len) @(negedge clk);
    #1;
    if (sel_b) rst_b = 1'b0;
    else       rst_a = 1'b0;
  endtask

  task automatic wait_k(input bit sel_b, input longint target, input string tag);
    int guard;
    guard = 0;
    while (((sel_b ? k_b : k_a) != target) && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(sel_b ? k_b : k_a), 32'(target));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // ten small frames: two sync lines of 16 clocks, one refresh point each
    wait_k(1'b1, 1760, "b_wait_frames");
    #2;
    check("b_vsync_low_clks", 32'(vs_low_b), 32'd320);
    check("b_refresh_point", 32'(tgt_b), 32'd10);
`ifdef VGA_FRAME_START_EN
    check("b_frame_start_cnt", 32'(fs_cnt_b), 32'd10);
`endif

    // one full 800-pixel line at 4 clocks per pixel
    wait_k(1'b0, 3200, "a_wait_line");
    #2;
    check("a_line_wrap_xy", {12'd0, if_a.x, if_a.y}, {12'd0, 10'd0, 10'd1});
    check("a_hsync_low_clks", 32'(hs_low_a), 32'd384);
    check("a_blank_clks", 32'(vid_off_a), 32'd640);

    // reset mid-line at x=300, y=2
    wait_k(1'b0, 7601, "a_wait_mid");
    drive_reset(1'b0, 1);
    check("a_mid_reset", {17'd0, if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.video_on},
          {17'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0});

    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(1, 600)) @(negedge clk);
      drive_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
    end
    repeat (800) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
